unidad_busqueda: RTL and testbench
==================================

Name: unidad_busqueda

Overview:
Instruction fetch stage for the ciscud CPU. It sits directly upstream of the 16x16-bit program/data memory, driving its address and read-enable and consuming its registered read data. It assembles one- or two-word instructions (opcode word plus optional immediate word) and presents them to the decoder over a valid/ready handshake. It accepts branch redirects from execute.

Parameters:
ANCHO_DIR, 16, width of PC and memory address.
PC_INICIO, 16'h0000, PC value loaded on reset.
OPC_LDI, 4'h4, opcode (bits [15:12]) of load-immediate; two-word instruction.
OPC_JMP, 4'hC, opcode of absolute jump; two-word instruction (target in second word).

Ports:
Reloj  input  1  clock; all state changes on rising edge.
ReiniciarN  input  1  reset; synchronous, active-low.
Direccion  output  ANCHO_DIR  memory address, registered.
HabilitarSalida  output  1  memory read enable, registered.
Salida  input  16  memory read data; valid the cycle after the memory samples an enabled read.
Saltar  input  1  redirect request from execute.
DireccionSalto  input  ANCHO_DIR  redirect target.
Instruccion  output  16  captured first word.
Inmediato  output  16  captured second word; 16'h0000 for one-word instructions.
TieneInmediato  output  1  instruction is two-word.
PCInstr  output  ANCHO_DIR  address of the first word.
InstrValida  output  1  Instruccion/Inmediato/TieneInmediato/PCInstr are valid.
InstrLista  input  1  decoder accepts; transfer when InstrValida && InstrLista.

Behaviour:
- Reset (ReiniciarN=0 at an edge): PC=PC_INICIO, state REPOSO, Direccion=0, HabilitarSalida=0, Instruccion=0, Inmediato=0, TieneInmediato=0, PCInstr=0, InstrValida=0. Reset mid-fetch discards everything. Reset has priority over Saltar.
- Fetch never writes memory. The memory write enable is owned elsewhere and is 0 whenever this block reads.
- States: REPOSO, PEDIR_I, CAPT_I, PEDIR_M, CAPT_M, ENTREGA.
- REPOSO -> PEDIR_I after one cycle. On entry to PEDIR_I: Direccion=PC, HabilitarSalida=1.
- PEDIR_I -> CAPT_I unconditionally. The memory samples at this edge.
- CAPT_I: at the edge, Instruccion=Salida and PCInstr=PC.
  - If Salida[15:12] is OPC_LDI or OPC_JMP: TieneInmediato=1, go to PEDIR_M with Direccion=PC+1 and HabilitarSalida=1.
  - Otherwise: TieneInmediato=0, Inmediato=0, HabilitarSalida=0, InstrValida=1, go to ENTREGA.
- PEDIR_M -> CAPT_M unconditionally.
- CAPT_M: Inmediato=Salida, HabilitarSalida=0, InstrValida=1, go to ENTREGA.
- Latency from entry into PEDIR_I to InstrValida: 2 cycles for one-word instructions, 4 cycles for two-word instructions.
- ENTREGA: outputs are held stable while InstrValida && !InstrLista. On transfer: InstrValida=0, PC += 1 (one-word) or 2 (two-word), go to PEDIR_I with the new PC.
- PC and Direccion arithmetic is modulo 2^ANCHO_DIR; 16'hFFFF+1 wraps to 16'h0000. The memory decodes only the low address bits, which is not this block's concern.
- Saltar=1 at an edge (reset deasserted), from any state:
  - PC=DireccionSalto, InstrValida=0, in-flight words are discarded.
  - Go to PEDIR_I with Direccion=DireccionSalto and HabilitarSalida=1.
  - Saltar wins over a simultaneous transfer in ENTREGA; that instruction counts as consumed, but PC takes DireccionSalto, not PC+n.
- Saltar held for several cycles: each edge restarts at PEDIR_I. Fetch progresses only after Saltar drops.
- HabilitarSalida is 1 only in PEDIR_I/CAPT_I and PEDIR_M/CAPT_M. Salida is sampled only in CAPT states, so a tri-stated memory bus is never captured.

Decomposition:
- Shared package ciscud_pkg: state encoding (3-bit enum), OPC_LDI, OPC_JMP, opcode field slice [15:12], instruction word width 16.
- One sub-module is natural: decodificador_longitud. It is combinational, takes a 16-bit word, and outputs whether the instruction is two-word. Decode-stage tests reuse it.

Test Plan:
- Reset then free-run: memory[0]=16'h4000, [1]=16'h0017, InstrLista=1 -> InstrValida 4 cycles after PEDIR_I with Instruccion=16'h4000, Inmediato=16'h0017, TieneInmediato=1, PCInstr=0; next fetch Direccion=2.
- One-word instruction: memory[2]=16'h1234 -> InstrValida 2 cycles after PEDIR_I, Inmediato=0, TieneInmediato=0, PCInstr=2; next Direccion=3.
- Backpressure: InstrLista=0 for 5 cycles in ENTREGA -> all outputs stable, HabilitarSalida=0, PC unchanged; InstrLista=1 -> single transfer.
- Redirect mid-fetch: Saltar=1, DireccionSalto=16'h000A in CAPT_M -> InstrValida stays 0, next Direccion=16'h000A, immediate discarded.
- Redirect coincident with transfer in ENTREGA: Saltar=1, DireccionSalto=5, InstrLista=1 -> Direccion=5, not PC+n.
- Wrap and reset: PC=16'hFFFF with a two-word opcode -> immediate read at 16'h0000, next PC=16'h0001. ReiniciarN=0 during PEDIR_M -> all outputs 0 next edge, PC=PC_INICIO.

Source files
------------

// File: rtl/ciscud_pkg.sv
// -----------------------------------------------------------------------------
// ciscud_pkg
// Definitions shared by the ciscud fetch and decode stages: instruction word
// width, the opcodes of the two-word instructions, the opcode field accessor
// and the fetch state encoding.
// -----------------------------------------------------------------------------
package ciscud_pkg;

   localparam int ANCHO_PALABRA = 16;

   // Opcodes that carry a second (immediate / target) word.
   localparam logic [3:0] OPC_LDI = 4'h4;
   localparam logic [3:0] OPC_JMP = 4'hC;

   typedef enum logic [2:0] {
      REPOSO  = 3'd0,
      PEDIR_I = 3'd1,
      CAPT_I  = 3'd2,
      PEDIR_M = 3'd3,
      CAPT_M  = 3'd4,
      ENTREGA = 3'd5
   } estado_t;

   // Opcode lives in the top nibble of the first instruction word.
   function automatic logic [3:0] campo_opcode(input logic [ANCHO_PALABRA-1:0] palabra);
      return palabra[15:12];
   endfunction

endpackage

// File: rtl/decodificador_longitud.sv
// -----------------------------------------------------------------------------
// decodificador_longitud
// Combinational instruction-length decoder: tells whether a first instruction
// word is followed by an immediate/target word.
//   palabra_i       in   16  first instruction word
//   dos_palabras_o  out   1  instruction is two words long
// -----------------------------------------------------------------------------
module decodificador_longitud #(
   parameter logic [3:0] OPC_LDI = ciscud_pkg::OPC_LDI,
   parameter logic [3:0] OPC_JMP = ciscud_pkg::OPC_JMP
) (
   input  logic [15:0] palabra_i,
   output logic        dos_palabras_o
);
   import ciscud_pkg::*;

   logic [3:0] opcode;

   assign opcode         = campo_opcode(palabra_i);
   assign dos_palabras_o = (opcode == OPC_LDI) || (opcode == OPC_JMP);

endmodule

// File: rtl/unidad_busqueda.sv
// -----------------------------------------------------------------------------
// unidad_busqueda
// Instruction fetch stage of the ciscud CPU. Reads one or two words from the
// registered-output program memory, assembles the instruction and hands it to
// the decoder over a valid/ready handshake. Execute can redirect at any time.
//   Reloj           in        clock
//   ReiniciarN      in        synchronous active-low reset
//   Direccion       out  AD   memory address (registered)
//   HabilitarSalida out   1   memory read enable (registered)
//   Salida          in   16   memory read data, one cycle after an enabled read
//   Saltar          in    1   redirect request
//   DireccionSalto  in   AD   redirect target
//   Instruccion     out  16   first word
//   Inmediato       out  16   second word, zero for one-word instructions
//   TieneInmediato  out   1   instruction is two words long
//   PCInstr         out  AD   address of the first word
//   InstrValida     out   1   instruction outputs are valid
//   InstrLista      in    1   decoder accepts the instruction
// -----------------------------------------------------------------------------
module unidad_busqueda #(
   parameter int                  ANCHO_DIR = 16,
   parameter logic [ANCHO_DIR-1:0] PC_INICIO = '0,
   parameter logic [3:0]          OPC_LDI   = ciscud_pkg::OPC_LDI,
   parameter logic [3:0]          OPC_JMP   = ciscud_pkg::OPC_JMP
) (
   input  logic                 Reloj,
   input  logic                 ReiniciarN,
   output logic [ANCHO_DIR-1:0] Direccion,
   output logic                 HabilitarSalida,
   input  logic [15:0]          Salida,
   input  logic                 Saltar,
   input  logic [ANCHO_DIR-1:0] DireccionSalto,
   output logic [15:0]          Instruccion,
   output logic [15:0]          Inmediato,
   output logic                 TieneInmediato,
   output logic [ANCHO_DIR-1:0] PCInstr,
   output logic                 InstrValida,
   input  logic                 InstrLista
);
   import ciscud_pkg::*;

   estado_t              estado_q, estado_d;
   logic [ANCHO_DIR-1:0] pc_q, pc_d;
   logic [ANCHO_DIR-1:0] dir_q, dir_d;
   logic                 hab_q, hab_d;
   logic [15:0]          instr_q, instr_d;
   logic [15:0]          inm_q, inm_d;
   logic                 tiene_q, tiene_d;
   logic [ANCHO_DIR-1:0] pcinstr_q, pcinstr_d;
   logic                 valida_q, valida_d;
   logic                 dos_palabras;
   logic [ANCHO_DIR-1:0] incremento;

   decodificador_longitud #(
      .OPC_LDI (OPC_LDI),
      .OPC_JMP (OPC_JMP)
   ) u_decodificador_longitud (
      .palabra_i      (Salida),
      .dos_palabras_o (dos_palabras)
   );

   assign incremento = tiene_q ? ANCHO_DIR'(2) : ANCHO_DIR'(1);

   always_comb begin
      // NOTE: every next-state value defaults to its register so that no path
      // through the case leaves a signal unassigned (which would infer a latch).
      estado_d  = estado_q;
      pc_d      = pc_q;
      dir_d     = dir_q;
      hab_d     = hab_q;
      instr_d   = instr_q;
      inm_d     = inm_q;
      tiene_d   = tiene_q;
      pcinstr_d = pcinstr_q;
      valida_d  = valida_q;

      case (estado_q)
         REPOSO: begin
            estado_d = PEDIR_I;
            dir_d    = pc_q;
            hab_d    = 1'b1;
         end
         PEDIR_I: estado_d = CAPT_I;
         CAPT_I: begin
            // Salida now holds the word read at pc_q.
            instr_d   = Salida;
            pcinstr_d = pc_q;
            if (dos_palabras) begin
               tiene_d  = 1'b1;
               dir_d    = pc_q + ANCHO_DIR'(1);
               hab_d    = 1'b1;
               estado_d = PEDIR_M;
            end else begin
               tiene_d  = 1'b0;
               inm_d    = 16'h0000;
               hab_d    = 1'b0;
               valida_d = 1'b1;
               estado_d = ENTREGA;
            end
         end
         PEDIR_M: estado_d = CAPT_M;
         CAPT_M: begin
            inm_d    = Salida;
            hab_d    = 1'b0;
            valida_d = 1'b1;
            estado_d = ENTREGA;
         end
         ENTREGA: begin
            if (valida_q && InstrLista) begin
               valida_d = 1'b0;
               pc_d     = pc_q + incremento;
               dir_d    = pc_q + incremento;
               hab_d    = 1'b1;
               estado_d = PEDIR_I;
            end
         end
         default: estado_d = REPOSO;
      endcase

      // A redirect overrides whatever the state machine chose this cycle,
      // including a transfer, and drops any word captured in this cycle.
      if (Saltar) begin
         instr_d   = instr_q;
         inm_d     = inm_q;
         tiene_d   = tiene_q;
         pcinstr_d = pcinstr_q;
         pc_d      = DireccionSalto;
         dir_d     = DireccionSalto;
         hab_d     = 1'b1;
         valida_d  = 1'b0;
         estado_d  = PEDIR_I;
      end
   end

   always_ff @(posedge Reloj) begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      if (!ReiniciarN) begin
         estado_q  <= REPOSO;
         pc_q      <= PC_INICIO;
         dir_q     <= '0;
         hab_q     <= 1'b0;
         instr_q   <= 16'h0000;
         inm_q     <= 16'h0000;
         tiene_q   <= 1'b0;
         pcinstr_q <= '0;
         valida_q  <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         pc_q      <= pc_d;
         dir_q     <= dir_d;
         hab_q     <= hab_d;
         instr_q   <= instr_d;
         inm_q     <= inm_d;
         tiene_q   <= tiene_d;
         pcinstr_q <= pcinstr_d;
         valida_q  <= valida_d;
      end
   end

   assign Direccion       = dir_q;
   assign HabilitarSalida = hab_q;
   assign Instruccion     = instr_q;
   assign Inmediato       = inm_q;
   assign TieneInmediato  = tiene_q;
   assign PCInstr         = pcinstr_q;
   assign InstrValida     = valida_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// -----------------------------------------------------------------------------
// tb_unidad_busqueda
// Directed bench for unidad_busqueda with a 16x16 registered-read memory model.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_unidad_busqueda;

   logic        Reloj;
   logic        ReiniciarN;
   logic [15:0] Direccion;
   logic        HabilitarSalida;
   logic [15:0] Salida;
   logic        Saltar;
   logic [15:0] DireccionSalto;
   logic [15:0] Instruccion;
   logic [15:0] Inmediato;
   logic        TieneInmediato;
   logic [15:0] PCInstr;
   logic        InstrValida;
   logic        InstrLista;

   logic [15:0] mem [16];

   int checks;
   int failures;

   unidad_busqueda #(
      .ANCHO_DIR (16),
      .PC_INICIO (16'h0000)
   ) dut (
      .Reloj           (Reloj),
      .ReiniciarN      (ReiniciarN),
      .Direccion       (Direccion),
      .HabilitarSalida (HabilitarSalida),
      .Salida          (Salida),
      .Saltar          (Saltar),
      .DireccionSalto  (DireccionSalto),
      .Instruccion     (Instruccion),
      .Inmediato       (Inmediato),
      .TieneInmediato  (TieneInmediato),
      .PCInstr         (PCInstr),
      .InstrValida     (InstrValida),
      .InstrLista      (InstrLista)
   );

   initial Reloj = 1'b0;
   always #5 Reloj = ~Reloj;

   // Memory decodes only the low four address bits; read data is registered.
   always @(posedge Reloj) begin
      if (HabilitarSalida) Salida <= mem[Direccion[3:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge Reloj);
   endtask

   // Called on the falling edge where the fetch has just entered PEDIR_I (or
   // any later point); counts falling edges until InstrValida rises.
   task automatic wait_valid(input int exp_ticks, input string tag);
      int n;
      n = 0;
      while (!InstrValida && n < 20) begin
         tick();
         n++;
      end
      check(tag, n, exp_ticks);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dir"},     Direccion,       32'h0);
      check({tag, "_hab"},     HabilitarSalida, 32'h0);
      check({tag, "_instr"},   Instruccion,     32'h0);
      check({tag, "_inm"},     Inmediato,       32'h0);
      check({tag, "_tiene"},   TieneInmediato,  32'h0);
      check({tag, "_pcinstr"}, PCInstr,         32'h0);
      check({tag, "_valida"},  InstrValida,     32'h0);
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      ReiniciarN     = 1'b0;
      Saltar         = 1'b0;
      DireccionSalto = 16'h0000;
      InstrLista     = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      mem[0]  = 16'h4000;   // LDI
      mem[1]  = 16'h0017;
      mem[2]  = 16'h1234;
      mem[3]  = 16'h2AB5;
      mem[4]  = 16'hC00F;   // JMP, its target word is discarded by a redirect
      mem[5]  = 16'h00EE;
      mem[10] = 16'h1111;
      mem[15] = 16'h4ABC;   // LDI at 16'hFFFF

      // Reset state.
      tick();
      tick();
      check_all_zero("reset");

      // Two-word LDI at address 0.
      ReiniciarN = 1'b1;
      tick();
      check("ldi_pedir_dir", Direccion, 32'h0000);
      check("ldi_pedir_hab", HabilitarSalida, 32'h1);
      wait_valid(4, "ldi_latency");
      check("ldi_instr",   Instruccion,     32'h4000);
      check("ldi_inm",     Inmediato,       32'h0017);
      check("ldi_tiene",   TieneInmediato,  32'h1);
      check("ldi_pcinstr", PCInstr,         32'h0000);
      check("ldi_hab_off", HabilitarSalida, 32'h0);

      // Transfer; next fetch at PC+2.
      tick();
      check("next_dir_2",    Direccion,       32'h0002);
      check("next_hab_2",    HabilitarSalida, 32'h1);
      check("next_valida_2", InstrValida,     32'h0);
      wait_valid(2, "one_latency");
      check("one_instr",   Instruccion,    32'h1234);
      check("one_inm",     Inmediato,      32'h0000);
      check("one_tiene",   TieneInmediato, 32'h0);
      check("one_pcinstr", PCInstr,        32'h0002);

      // Transfer; next fetch at PC+1, then hold it off for 5 cycles.
      tick();
      check("next_dir_3", Direccion, 32'h0003);
      InstrLista = 1'b0;
      wait_valid(2, "bp_latency");
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valida",  InstrValida,     32'h1);
         check("bp_instr",   Instruccion,     32'h2AB5);
         check("bp_pcinstr", PCInstr,         32'h0003);
         check("bp_hab",     HabilitarSalida, 32'h0);
         check("bp_dir",     Direccion,       32'h0003);
      end
      InstrLista = 1'b1;
      tick();
      check("bp_xfer_valida", InstrValida,     32'h0);
      check("bp_xfer_dir",    Direccion,       32'h0004);
      check("bp_xfer_hab",    HabilitarSalida, 32'h1);

      // JMP at 4, redirected to 16'h000A while in CAPT_M.
      tick();
      tick();
      check("jmp_imm_dir", Direccion, 32'h0005);
      tick();
      check("jmp_captm_valida", InstrValida, 32'h0);
      Saltar         = 1'b1;
      DireccionSalto = 16'h000A;
      tick();
      Saltar = 1'b0;
      check("redir_valida", InstrValida,     32'h0);
      check("redir_dir",    Direccion,       32'h000A);
      check("redir_hab",    HabilitarSalida, 32'h1);
      check("redir_inm",    Inmediato,       32'h0000);
      InstrLista = 1'b0;
      wait_valid(2, "redir_latency");
      check("redir_instr",   Instruccion, 32'h1111);
      check("redir_pcinstr", PCInstr,     32'h000A);

      // Redirect coincident with a transfer: target wins over PC+1.
      Saltar         = 1'b1;
      DireccionSalto = 16'h0005;
      InstrLista     = 1'b1;
      tick();
      Saltar     = 1'b0;
      InstrLista = 1'b0;
      check("coinc_dir",    Direccion,       32'h0005);
      check("coinc_hab",    HabilitarSalida, 32'h1);
      check("coinc_valida", InstrValida,     32'h0);
      wait_valid(2, "coinc_latency");
      check("coinc_instr",   Instruccion, 32'h00EE);
      check("coinc_pcinstr", PCInstr,     32'h0005);

      // Address wrap: LDI at 16'hFFFF reads its immediate at 16'h0000.
      mem[0]         = 16'h0017;
      Saltar         = 1'b1;
      DireccionSalto = 16'hFFFF;
      tick();
      Saltar = 1'b0;
      check("wrap_dir",    Direccion,   32'hFFFF);
      check("wrap_valida", InstrValida, 32'h0);
      tick();
      tick();
      check("wrap_imm_dir", Direccion,       32'h0000);
      check("wrap_imm_hab", HabilitarSalida, 32'h1);
      wait_valid(2, "wrap_latency");
      check("wrap_instr",   Instruccion,    32'h4ABC);
      check("wrap_inm",     Inmediato,      32'h0017);
      check("wrap_tiene",   TieneInmediato, 32'h1);
      check("wrap_pcinstr", PCInstr,        32'hFFFF);
      mem[1]     = 16'hC003;
      InstrLista = 1'b1;
      tick();
      InstrLista = 1'b0;
      check("wrap_next_dir", Direccion, 32'h0001);

      // Reset in PEDIR_M of the JMP at address 1.
      tick();
      tick();
      check("rst_pedirm_dir", Direccion, 32'h0002);
      ReiniciarN = 1'b0;
      tick();
      check_all_zero("midrst");
      ReiniciarN = 1'b1;
      tick();
      check("post_rst_dir", Direccion,       32'h0000);
      check("post_rst_hab", HabilitarSalida, 32'h1);
      wait_valid(2, "post_rst_latency");
      check("post_rst_instr",   Instruccion,    32'h0017);
      check("post_rst_pcinstr", PCInstr,        32'h0000);
      check("post_rst_tiene",   TieneInmediato, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
